// File: rtl/pc_redirect_if.sv
// Fetch-PC control bundle: EX/hazard requests toward pc_redirect, fetch PC and pipeline control back.
interface pc_redirect_if;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        halted;
  logic        misalign;

  modport master (
    output branch_taken, jump, target, stall, halt,
    input  pc, pc_plus4, flush, halted, misalign
  );

  modport slave (
    input  branch_taken, jump, target, stall, halt,
    output pc, pc_plus4, flush, halted, misalign
  );
endinterface

// File: rtl/pc_redirect.sv
// Fetch PC sequencer (RUN/FLUSH/HALT): pc updates one edge after its input cycle; stall holds pc.
// Optional MISALIGN_TRAP_EN sends misaligned redirects to TRAP_PC and pulses misalign.
module pc_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0010
) (
  input logic          clk,
  input logic          rst,
  pc_redirect_if.slave bus
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

  localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);
  // A one-cycle flush never needs the FLUSH state: the pulse drops on the next RUN edge.
  localparam state_e     REDIR_STATE = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] load_pc;
  logic        load_mis;

  assign redirect = bus.branch_taken | bus.jump;

`ifdef MISALIGN_TRAP_EN
  assign load_mis = |bus.target[1:0];
  assign load_pc  = load_mis ? TRAP_PC : bus.target;
`else
  logic unused_trap;
  assign load_mis    = 1'b0;
  assign load_pc     = {bus.target[31:2], 2'b00};
  assign unused_trap = ^{TRAP_PC, bus.target[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;
    case (state_q)
      RUN: begin
        flush_d = 1'b0;
        if (bus.halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (redirect) begin
          pc_d       = load_pc;
          misalign_d = load_mis;
          flush_d    = 1'b1;
          cnt_d      = FLUSH_LAST;
          state_d    = REDIR_STATE;
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FLUSH: begin
        // Redirect/halt here come from squashed instructions and are dropped.
        if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALT: begin
        flush_d = 1'b0;
      end
      default: begin
        state_d = RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;
  assign bus.flush    = flush_q;
  assign bus.halted   = halted_q;
  assign bus.misalign = misalign_q;

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, sets the flush pulse length in cycles (legal range 1..7) and equals the number of younger in-flight instructions to squash.
REQ-003 Parameter TRAP_PC, default 32'h0000_0010, is the vector used on a misaligned redirect (only with MISALIGN_TRAP_EN).
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 branch_taken  in  1  taken-branch decision from the branch control unit (EX stage).
REQ-007 jump  in  1  unconditional jal/jalr redirect (EX stage).
REQ-008 target  in  32  redirect target address from EX.
REQ-009 stall  in  1  load-use hazard; hold PC.
REQ-010 halt  in  1  ecall/ebreak/fence retire request; freeze fetch.
REQ-011 pc  out  32  current fetch address (registered).
REQ-012 pc_plus4  out  32  pc + 4, combinational from pc.
REQ-013 flush  out  1  squash younger pipeline registers (registered).
REQ-014 halted  out  1  high while in HALT (registered).
REQ-015 misalign  out  1  one-cycle pulse on trapped misaligned redirect.

Function
REQ-016 The block SHALL implement states RUN, FLUSH, HALT; redirect = (branch_taken | jump).
REQ-017 In RUN, priority SHALL be halt > redirect > stall > sequential.
REQ-018 In RUN with halt=1: next pc = pc, next state HALT, halted=1 from the next cycle.
REQ-019 In RUN with redirect=1: next pc = target, flush=1 and counter=FLUSH_CYCLES-1 from the next cycle, next state FLUSH (or RUN with single-cycle flush if FLUSH_CYCLES=1); stall is ignored that cycle.
REQ-020 In RUN with stall=1 and no redirect: pc held, flush stays 0.
REQ-021 In RUN otherwise: next pc = pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 In FLUSH, flush SHALL remain 1; counter decrements each cycle; at counter 0 flush drops to 0 and state returns to RUN on the next edge.
REQ-023 In FLUSH, branch_taken, jump and halt SHALL be ignored (they originate from squashed instructions); pc advances by 4 unless stall=1.
REQ-024 Total flush high time per redirect SHALL be exactly FLUSH_CYCLES cycles.
REQ-025 In HALT, pc SHALL be frozen, flush=0, all inputs ignored; only reset exits HALT.
REQ-026 Latency: any PC change is visible on pc exactly one clock edge after the qualifying input cycle.

Reset
REQ-027 On rst=0, asynchronously: pc=RESET_PC, flush=0, halted=0, misalign=0, counter=0, state=RUN.
REQ-028 Reset asserted mid-FLUSH or in HALT SHALL abort that state with no residual flush pulse after release.
REQ-029 The first pc increment SHALL occur on the first rising edge with rst=1.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN SHALL control misaligned-target trapping.
REQ-031 With MISALIGN_TRAP_EN defined: on an accepted redirect with target[1:0] != 2'b00, next pc = TRAP_PC, misalign pulses 1 for one cycle, and flush behaves per REQ-019.
REQ-032 Without MISALIGN_TRAP_EN: target[1:0] is forced to 2'b00 on load, misalign is tied to 0, and TRAP_PC is unused.

Verification
REQ-033 Reset release with RESET_PC=0, no inputs, 4 edges -> pc = 0,4,8,12,16; flush=0 throughout.
REQ-034 At pc=0x20: branch_taken=1, target=0x100 for one cycle -> pc=0x100 next edge, flush=1 for exactly 2 cycles, then pc=0x104,0x108; jump=1 asserted during flush is ignored.
REQ-035 stall=1 for 3 cycles at pc=0x40 -> pc holds 0x40; stall=1 together with jump=1 target=0x80 -> pc=0x80 (redirect wins).
REQ-036 halt=1 at pc=0x60 -> pc frozen at 0x60, halted=1, subsequent jump/branch ignored; rst=0 -> pc=RESET_PC, halted=0.
REQ-037 With MISALIGN_TRAP_EN: jump=1 target=0x102 -> pc=TRAP_PC (0x10), misalign one-cycle pulse, flush 2 cycles; without macro: pc=0x100, misalign=0.
REQ-038 pc=0xFFFF_FFFC, no stall -> pc=0x0000_0000; rst=0 asserted in second flush cycle -> flush=0 immediately and after release.
